// File: rtl/instr_dispatch_fsm_if.sv
// Sequencer bus: instruction handshake in, operand/start fan-out
// to the execution FSMs, done fan-in and status back out.
interface instr_dispatch_fsm_if #(
  parameter int CNT_W = 16
) ();
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic [3:0]       opCode;
  logic [5:0]       Ri;
  logic [5:0]       num;
  logic             mov_start;
  logic             movi_start;
  logic             alu_start;
  logic             alui_start;
  logic             mov_done;
  logic             movi_done;
  logic             alu_done;
  logic             alui_done;
  logic             busy;
  logic             halted;
  logic             protocol_err;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr_valid, instr,
    input  mov_done, movi_done,
    input  alu_done, alui_done,
    output instr_ready, opCode, Ri, num,
    output mov_start, movi_start,
    output alu_start, alui_start,
    output busy, halted, protocol_err,
    output timeout, retired
  );

  modport slave (
    output instr_valid, instr,
    output mov_done, movi_done,
    output alu_done, alui_done,
    input  instr_ready, opCode, Ri, num,
    input  mov_start, movi_start,
    input  alu_start, alui_start,
    input  busy, halted, protocol_err,
    input  timeout, retired
  );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Instruction sequencer: one execution FSM owns the bus at a time.
// Optional WAIT watchdog enabled by defining CTRL_TIMEOUT_EN.
module instr_dispatch_fsm #(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 16
) (
  input logic                  clk,
  input logic                  reset,
  instr_dispatch_fsm_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT,
    HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic             halt_q, halt_d;
  logic [3:0]       op_q;
  logic [5:0]       ri_q;
  logic [5:0]       num_q;
  logic [CNT_W-1:0] ret_q;
  logic             perr_q;
  logic             tmo_q;
  logic [3:0]       done_v;
  logic             accept;
  logic             sel_done;
  logic             stray_done;
  logic             retire;
  logic             tmo_hit;

  // unit vectors are ordered {alui, alu, movi, mov}
  assign done_v = {bus.alui_done, bus.alu_done,
                   bus.movi_done, bus.mov_done};

  assign accept   = bus.instr_valid && (state_q == IDLE);
  assign sel_done = |(done_v & sel_q);

  assign stray_done = (|(done_v & ~sel_q)) ||
                      ((|done_v) && (state_q != WAIT));

  always_comb begin
    sel_d  = 4'b0000;
    halt_d = 1'b0;
    unique case (1'b1)
      bus.instr[15]:                  sel_d  = 4'b0100;
      bus.instr[15:14] == 2'b01:      sel_d  = 4'b1000;
      bus.instr[15:12] == 4'h1:       sel_d  = 4'b0001;
      bus.instr[15:12] == 4'h2:       sel_d  = 4'b0010;
      bus.instr[15:12] == 4'h3:       halt_d = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
    end else if (state_q == DISPATCH) begin
      wcnt_q <= '0;
    end else if (state_q == WAIT) begin
      wcnt_q <= wcnt_q + TW'(1);
    end
  end

  // a done landing on the last WAIT cycle still retires
  assign tmo_hit = (state_q == WAIT) && !sel_done &&
                   (wcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DISPATCH;
      end
      DISPATCH: begin
        if (halt_q) begin
          state_d = HALTED;
        end else if (sel_q == 4'b0000) begin
          state_d = IDLE;
          retire  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_done) begin
          state_d = IDLE;
          retire  = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      HALTED: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 4'b0000;
      halt_q  <= 1'b0;
      op_q    <= 4'h0;
      ri_q    <= 6'h00;
      num_q   <= 6'h00;
      ret_q   <= '0;
      perr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q  <= sel_d;
        halt_q <= halt_d;
        op_q   <= bus.instr[15:12];
        ri_q   <= bus.instr[11:6];
        num_q  <= bus.instr[5:0];
      end
      if (retire)     ret_q  <= ret_q + CNT_W'(1);
      if (stray_done) perr_q <= 1'b1;
      if (tmo_hit)    tmo_q  <= 1'b1;
    end
  end

  assign bus.instr_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q == DISPATCH) ||
                            (state_q == WAIT);
  assign bus.halted       = (state_q == HALTED);
  assign bus.opCode       = op_q;
  assign bus.Ri           = ri_q;
  assign bus.num          = num_q;
  assign bus.protocol_err = perr_q;
  assign bus.timeout      = tmo_q;
  assign bus.retired      = ret_q;

  assign {bus.alui_start, bus.alu_start,
          bus.movi_start, bus.mov_start} =
    (state_q == DISPATCH) ? sel_q : 4'b0000;
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Directed + randomized checks of the instruction sequencer
// against a transaction-level model of its decode and timing.
module tb_instr_dispatch_fsm;
  localparam int CW = 4;
  localparam int TO = 8;
  localparam int U_NOP  = -1;
  localparam int U_HALT = -2;

  logic clk;
  logic reset;

  instr_dispatch_fsm_if #(.CNT_W(CW)) bus ();

  instr_dispatch_fsm #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;
  int ret_m;
  int st_cnt [4];
  int st_cyc;
  bit multi;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] starts();
    return {bus.alui_start, bus.alu_start,
            bus.movi_start, bus.mov_start};
  endfunction

  // unit index: 0 mov, 1 movi, 2 alu, 3 alui
  function automatic int unit_of(input logic [3:0] op);
    if (op[3])          return 2;
    if (op[3:2] == 2'b01) return 3;
    if (op == 4'h1)     return 0;
    if (op == 4'h2)     return 1;
    if (op == 4'h3)     return U_HALT;
    return U_NOP;
  endfunction

  task automatic set_done(input int u);
    bus.mov_done  = (u == 0);
    bus.movi_done = (u == 1);
    bus.alu_done  = (u == 2);
    bus.alui_done = (u == 3);
  endtask

  task automatic tick();
    logic [3:0] s;
    @(posedge clk);
    #1;
    cyc++;
    s = starts();
    if ($countones(s) > 1) multi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (s[k]) begin
        if (st_cyc < 0) st_cyc = cyc;
        st_cnt[k]++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    set_done(-1);
    tick();
    tick();
    reset = 1'b0;
    ret_m = 0;
  endtask

  task automatic clr_mon();
    for (int k = 0; k < 4; k++) st_cnt[k] = 0;
    st_cyc = -1;
    multi = 1'b0;
  endtask

  // Issue one instruction; unit responds n cycles after
  // sampling its start pulse.
  task automatic run(input logic [15:0] w,
                     input int n, input bit noisy);
    int u, acc, lat, exp_lat, tot;
    u = unit_of(w[15:12]);
    chk("ready_pre", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr = w;
    acc = cyc;
    clr_mon();
    tick();
    if (noisy) bus.instr = 16'($urandom);
    else bus.instr_valid = 1'b0;
    chk("opcode", bus.opCode, w[15:12]);
    chk("ri", bus.Ri, w[11:6]);
    chk("num", bus.num, w[5:0]);
    chk("busy_disp", bus.busy, 1);
    if (u == U_HALT) begin
      tick();
      chk("halted", bus.halted, 1);
      chk("ready_halt", bus.instr_ready, 0);
      chk("ret_halt", bus.retired, ret_m);
      return;
    end
    exp_lat = (u == U_NOP) ? 2 : 3 + n;
    while (!bus.instr_ready && (cyc - acc) < 300) begin
      if (u >= 0 && (cyc - acc) == n + 2) set_done(u);
      else set_done(-1);
      tick();
    end
    set_done(-1);
    lat = cyc - acc;
    ret_m = (ret_m + 1) % (1 << CW);
    chk("latency", lat, exp_lat);
    chk("retired", bus.retired, ret_m);
    chk("busy_end", bus.busy, 0);
    chk("one_start", multi, 0);
    tot = st_cnt[0] + st_cnt[1] + st_cnt[2] + st_cnt[3];
    if (u >= 0) begin
      chk("start_cnt", st_cnt[u], 1);
      chk("start_tot", tot, 1);
      chk("start_cyc", st_cyc - acc, 1);
    end else begin
      chk("nop_nostart", tot, 0);
    end
  endtask

  initial begin
    logic [15:0] w;
    int acc;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    clr_mon();
    do_reset();

    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_perr", bus.protocol_err, 0);
    chk("rst_tmo", bus.timeout, 0);
    chk("rst_ret", bus.retired, 0);
    chk("rst_op", {bus.opCode, bus.Ri, bus.num}, 0);
    chk("rst_starts", starts(), 0);

    run(16'h503F, 4, 1'b0);

    run(16'h1042, 2, 1'b1);
    run(16'h2abc, 0, 1'b1);
    run(16'h8123, 3, 1'b1);
    run(16'h0000, 0, 1'b1);
    bus.instr_valid = 1'b0;
    chk("b2b_ret", bus.retired, 5);
    chk("b2b_perr", bus.protocol_err, 0);

    // foreign done during MOV wait, then the real one
    bus.instr_valid = 1'b1;
    bus.instr = 16'h1041;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    set_done(2);
    tick();
    set_done(-1);
    chk("perr_set", bus.protocol_err, 1);
    chk("perr_noret", bus.retired, ret_m);
    chk("perr_busy", bus.busy, 1);
    set_done(0);
    tick();
    set_done(-1);
    ret_m = (ret_m + 1) % (1 << CW);
    chk("perr_ready", bus.instr_ready, 1);
    chk("perr_ret", bus.retired, ret_m);
    tick();
    chk("perr_sticky", bus.protocol_err, 1);

    // selected done in DISPATCH ignored; mixed done retires
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr = 16'h9000;
    tick();
    bus.instr_valid = 1'b0;
    set_done(2);
    tick();
    set_done(-1);
    chk("disp_done_busy", bus.busy, 1);
    chk("disp_done_ret", bus.retired, 0);
    chk("disp_done_perr", bus.protocol_err, 1);
    bus.alu_done = 1'b1;
    bus.mov_done = 1'b1;
    tick();
    set_done(-1);
    chk("mix_ready", bus.instr_ready, 1);
    chk("mix_ret", bus.retired, 1);

    // done while idle is a protocol error
    do_reset();
    set_done(1);
    tick();
    set_done(-1);
    chk("idle_done_perr", bus.protocol_err, 1);
    chk("idle_done_ret", bus.retired, 0);

    // random traffic; 4-bit counter wraps several times
    do_reset();
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'h3) w[15:12] = 4'h0;
      run(w, $urandom_range(0, 6), 1'($urandom));
    end
    bus.instr_valid = 1'b0;
    chk("rnd_perr", bus.protocol_err, 0);

    // MOVI whose unit never answers
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr = 16'h2000;
    acc = cyc;
    tick();
    bus.instr_valid = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    while (!bus.instr_ready && (cyc - acc) < 60) tick();
    chk("tmo_lat", cyc - acc, TO + 2);
    chk("tmo_flag", bus.timeout, 1);
    chk("tmo_ret", bus.retired, 0);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("hang_busy", bus.busy, 1);
    chk("hang_tmo", bus.timeout, 0);
    chk("hang_ret", bus.retired, 0);
`endif

    // reset in the middle of an ALU wait
    do_reset();
    bus.instr_valid = 1'b1;
    bus.instr = 16'h8123;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw_ready", bus.instr_ready, 1);
    chk("rstw_ret", bus.retired, 0);
    chk("rstw_starts", starts(), 0);
    chk("rstw_busy", bus.busy, 0);

    // HALT is terminal until reset
    run(16'h3000, 0, 1'b0);
    clr_mon();
    for (int i = 0; i < 5; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr = 16'h1000 + 16'(i);
      tick();
    end
    bus.instr_valid = 1'b0;
    chk("halt_stay", bus.halted, 1);
    chk("halt_ready", bus.instr_ready, 0);
    chk("halt_ret", bus.retired, 0);
    chk("halt_nostart", st_cnt[0] + st_cnt[1] +
                        st_cnt[2] + st_cnt[3], 0);
    do_reset();
    chk("unhalt", bus.halted, 0);
    chk("unhalt_ready", bus.instr_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
